// File: rtl/inexact_div16.sv
// Sequential 16-by-8 restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define INEXACT_DIV_TRUNC_EN to skip the TRUNC_BITS low quotient bits (approximate, shorter latency).
module inexact_div16 #(
    parameter int unsigned TRUNC_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quot,
    output logic [7:0]  rem,
    output logic        div_zero
);

`ifdef INEXACT_DIV_TRUNC_EN
    localparam int unsigned SKIP = TRUNC_BITS;
`else
    // TRUNC_BITS stays on the parameter list so overrides remain legal in the exact build
    localparam int unsigned SKIP = 0 * TRUNC_BITS;
`endif
    localparam int unsigned N    = 16 - SKIP;
    localparam logic [4:0]  LAST = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [15:0] dvd_q;
    logic [7:0]  dvs_q;
    logic [7:0]  r_q;
    logic [14:0] qw_q;
    logic [4:0]  cnt_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [15:0] quot_q;
    logic [7:0]  rem_q;
    logic        dz_q;

    logic [8:0]  r_shift_d;
    logic        qbit_d;
    logic [7:0]  r_d;
    logic [15:0] qw_d;

    // The subtracted remainder is always below the divisor, so 8 bits hold it.
    always_comb begin
        r_shift_d = {r_q, dvd_q[15]};
        qbit_d    = (r_shift_d >= {1'b0, dvs_q});
        r_d       = qbit_d ? 8'(r_shift_d - {1'b0, dvs_q}) : r_shift_d[7:0];
        qw_d      = {qw_q, qbit_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            r_q         <= '0;
            qw_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dz_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q      <= dividend;
                        dvs_q      <= divisor;
                        r_q        <= '0;
                        qw_q       <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (divisor == 8'd0) begin
                            quot_q      <= '1;
                            rem_q       <= dividend[7:0];
                            dz_q        <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    dvd_q <= {dvd_q[14:0], 1'b0};
                    r_q   <= r_d;
                    qw_q  <= qw_d[14:0];
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST) begin
                        // Only N quotient bits were produced; align them to the top.
                        quot_q      <= qw_d << SKIP;
                        rem_q       <= r_d;
                        dz_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_inexact_div16.sv
// Self-checking bench for inexact_div16: directed cases, backpressure, mid-op reset and a random sweep
// against an arithmetic reference model; honours INEXACT_DIV_TRUNC_EN like the design.
module tb_inexact_div16;

    localparam int unsigned TB_TRUNC = 4;
`ifdef INEXACT_DIV_TRUNC_EN
    localparam int unsigned S = TB_TRUNC;
`else
    localparam int unsigned S = 0;
`endif
    localparam int unsigned NLAT = 16 - S;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic        div_zero;

    int compared   = 0;
    int mismatched = 0;

    inexact_div16 #(.TRUNC_BITS(TB_TRUNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: divide the kept high part of the dividend, then re-align the quotient.
    task automatic model(input logic [15:0] dd, input logic [7:0] dv,
                         output logic [15:0] eq, output logic [7:0] er, output logic ez);
        logic [15:0] s;
        if (dv == 8'd0) begin
            eq = 16'hFFFF;
            er = dd[7:0];
            ez = 1'b1;
        end else begin
            s  = dd >> S;
            eq = 16'((s / {8'd0, dv}) << S);
            er = 8'(s % {8'd0, dv});
            ez = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                          input int hold, input bit pulse);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int          lat;
        int          explat;
        model(dd, dv, eq, er, ez);
        explat = ez ? 0 : int'(NLAT);
        check({tag, ":in_ready_before"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        dividend  = dd;
        divisor   = dv;
        tick();
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            check({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(explat));
        check({tag, ":quot"}, 32'(quot), 32'(eq));
        check({tag, ":rem"}, 32'(rem), 32'(er));
        check({tag, ":div_zero"}, 32'(div_zero), 32'(ez));
`ifdef INEXACT_DIV_TRUNC_EN
        if (!ez)
            check({tag, ":trunc_bound"},
                  32'((int'(dd) / int'(dv) >= int'(quot)) && (int'(dd) / int'(dv) < int'(quot) + 16)),
                  32'd1);
`endif
        for (int k = 0; k < hold; k++) begin
            if (pulse && k == 1) begin
                in_valid = 1'b1;
                dividend = 16'h0F0F;
                divisor  = 8'd3;
            end
            tick();
            in_valid = 1'b0;
            check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ":hold_quot"}, 32'(quot), 32'(eq));
            check({tag, ":hold_rem"}, 32'(rem), 32'(er));
            check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check({tag, ":valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ":in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, ":quot_kept"}, 32'(quot), 32'(eq));
    endtask

    initial begin
        int seen;
        logic [15:0] rdd;
        logic [7:0]  rdv;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) tick();
        check("reset:in_ready", 32'(in_ready), 32'd1);
        check("reset:out_valid", 32'(out_valid), 32'd0);
        check("reset:quot", 32'(quot), 32'd0);
        check("reset:rem", 32'(rem), 32'd0);
        check("reset:div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("d1000_7", 16'd1000, 8'd7, 0, 1'b0);
`ifdef INEXACT_DIV_TRUNC_EN
        check("d1000_7:const_quot", 32'(quot), 32'd128);
`else
        check("d1000_7:const_quot", 32'(quot), 32'd142);
`endif
        check("d1000_7:const_rem", 32'(rem), 32'd6);
        run_op("dFFFF_1", 16'hFFFF, 8'd1, 0, 1'b0);
        run_op("d5_200", 16'd5, 8'd200, 0, 1'b0);
        run_op("dz_1234", 16'h1234, 8'd0, 0, 1'b0);
        run_op("bp_500_3", 16'd500, 8'd3, 5, 1'b1);
        run_op("after_bp", 16'd4321, 8'd19, 0, 1'b0);
        run_op("dz_bp", 16'hABCD, 8'd0, 3, 1'b1);

        // Reset lands on the seventh BUSY iteration.
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid:in_ready", 32'(in_ready), 32'd1);
        check("rst_mid:out_valid", 32'(out_valid), 32'd0);
        check("rst_mid:quot", 32'(quot), 32'd0);
        check("rst_mid:rem", 32'(rem), 32'd0);
        check("rst_mid:div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_mid:no_result", 32'(seen), 32'd0);
        run_op("post_rst", 16'd1000, 8'd7, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rdd = 16'($urandom);
            rdv = (i % 8 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op($sformatf("rand%0d", i), rdd, rdv, i % 3, (i % 4) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
